// File: rtl/ptp_stamp_arbiter.sv
// PTP timestamp arbiter: edge-detects per-slot stamp events, latches the counter per slot,
// and serialises pending stamps through a round-robin arbiter onto one valid/ready record.
module ptp_stamp_arbiter #(
    parameter int unsigned NUM_PORTS     = 4,
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned PORT_ID_W     = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic [COUNTER_WIDTH-1:0]   counter_val,
    input  logic [2*NUM_PORTS-1:0]     stamp_evt,
    output logic                       out_valid,
    input  logic                       out_rdy,
    output logic [COUNTER_WIDTH-1:0]   out_stamp,
    output logic [PORT_ID_W-1:0]       out_port,
    output logic                       out_dir,
    output logic                       out_lost,
    output logic [15:0]                drop_cnt
);

    localparam int unsigned NumReq = 2 * NUM_PORTS;
    localparam int unsigned IdxW   = $clog2(NumReq);

    typedef enum logic {StIdle, StHold} state_e;

    state_e                   state_q, state_d;
    logic [NumReq-1:0]        evt_q;
    logic [NumReq-1:0]        pending_q, pending_d;
    logic [NumReq-1:0]        lost_q, lost_d;
    logic [COUNTER_WIDTH-1:0] stamp_q [NumReq];
    logic [COUNTER_WIDTH-1:0] stamp_d [NumReq];
    logic [IdxW-1:0]          rr_q, rr_d;
    logic [COUNTER_WIDTH-1:0] out_stamp_q, out_stamp_d;
    logic [PORT_ID_W-1:0]     out_port_q, out_port_d;
    logic                     out_dir_q, out_dir_d;
    logic                     out_lost_q, out_lost_d;
    logic [15:0]              drop_cnt_q, drop_cnt_d;

    logic [NumReq-1:0]        cap;
    logic [NumReq-1:0]        drop_vec;
    logic                     can_load;
    logic                     gnt;
    logic                     any_pend;
    logic [IdxW-1:0]          gnt_idx;
    logic [16:0]              drop_sum;

    assign cap      = stamp_evt & ~evt_q & {NumReq{en}};
    assign can_load = (state_q == StIdle) | out_rdy;
    assign gnt      = can_load & any_pend;

    // Walk downward so the nearest pending slot after rr_q is the last one written.
    always_comb begin
        any_pend = 1'b0;
        gnt_idx  = '0;
        for (int unsigned k = NumReq; k >= 1; k--) begin
            if (pending_q[(int'(rr_q) + k) % NumReq]) begin
                any_pend = 1'b1;
                gnt_idx  = IdxW'((int'(rr_q) + k) % NumReq);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        lost_d      = lost_q;
        stamp_d     = stamp_q;
        rr_d        = rr_q;
        out_stamp_d = out_stamp_q;
        out_port_d  = out_port_q;
        out_dir_d   = out_dir_q;
        out_lost_d  = out_lost_q;
        drop_vec    = '0;

        if (can_load) begin
            state_d = gnt ? StHold : StIdle;
        end
        if (gnt) begin
            out_stamp_d        = stamp_q[gnt_idx];
            out_port_d         = PORT_ID_W'(gnt_idx >> 1);
            out_dir_d          = gnt_idx[0];
            out_lost_d         = lost_q[gnt_idx];
            pending_d[gnt_idx] = 1'b0;
            lost_d[gnt_idx]    = 1'b0;
            rr_d               = gnt_idx;
        end

        // A slot granted this cycle counts as free, so a same-cycle event is kept, not dropped.
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (cap[i]) begin
                if (!pending_d[i]) begin
                    stamp_d[i]   = counter_val;
                    pending_d[i] = 1'b1;
                    lost_d[i]    = 1'b0;
                end else begin
                    lost_d[i]   = 1'b1;
                    drop_vec[i] = 1'b1;
                end
            end
        end

        drop_sum   = {1'b0, drop_cnt_q} + 17'($countones(drop_vec));
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            evt_q       <= '0;
            pending_q   <= '0;
            lost_q      <= '0;
            rr_q        <= IdxW'(NumReq - 1);
            out_stamp_q <= '0;
            out_port_q  <= '0;
            out_dir_q   <= 1'b0;
            out_lost_q  <= 1'b0;
            drop_cnt_q  <= '0;
            for (int unsigned i = 0; i < NumReq; i++) begin
                stamp_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            evt_q       <= stamp_evt;
            pending_q   <= pending_d;
            lost_q      <= lost_d;
            rr_q        <= rr_d;
            out_stamp_q <= out_stamp_d;
            out_port_q  <= out_port_d;
            out_dir_q   <= out_dir_d;
            out_lost_q  <= out_lost_d;
            drop_cnt_q  <= drop_cnt_d;
            for (int unsigned i = 0; i < NumReq; i++) begin
                stamp_q[i] <= stamp_d[i];
            end
        end
    end

    assign out_valid = (state_q == StHold);
    assign out_stamp = out_stamp_q;
    assign out_port  = out_port_q;
    assign out_dir   = out_dir_q;
    assign out_lost  = out_lost_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_ptp_stamp_arbiter.sv
// Bench for ptp_stamp_arbiter: directed scenarios plus random traffic, all checked each cycle
// against a slot-level reference model of pending stamps, round-robin grants and drop counting.
module tb_ptp_stamp_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b1;
    logic [31:0] counter_val = '0;
    logic [7:0]  stamp_evt = '0;
    logic        out_valid;
    logic        out_rdy = 1'b0;
    logic [31:0] out_stamp;
    logic [1:0]  out_port;
    logic        out_dir;
    logic        out_lost;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_pend [8];
    bit          m_lost [8];
    logic [31:0] m_stamp [8];
    int          m_rr;
    logic [7:0]  m_evt;
    bit          m_valid;
    logic [31:0] m_out_stamp;
    int          m_out_slot;
    bit          m_out_lost;
    int          m_drop;

    ptp_stamp_arbiter #(
        .NUM_PORTS    (4),
        .COUNTER_WIDTH(32),
        .PORT_ID_W    (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .counter_val(counter_val),
        .stamp_evt  (stamp_evt),
        .out_valid  (out_valid),
        .out_rdy    (out_rdy),
        .out_stamp  (out_stamp),
        .out_port   (out_port),
        .out_dir    (out_dir),
        .out_lost   (out_lost),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_pend[i]  = 0;
            m_lost[i]  = 0;
            m_stamp[i] = '0;
        end
        m_rr        = 7;
        m_evt       = '0;
        m_valid     = 0;
        m_out_stamp = '0;
        m_out_slot  = 0;
        m_out_lost  = 0;
        m_drop      = 0;
    endtask

    // One clock edge of the specified behaviour, from the inputs presented before the edge.
    task automatic model_step();
        int g;
        int drops;
        g     = -1;
        drops = 0;
        if (!m_valid || out_rdy) begin
            for (int k = 1; k <= 8; k++) begin
                if (g < 0 && m_pend[(m_rr + k) % 8]) g = (m_rr + k) % 8;
            end
            m_valid = (g >= 0);
        end
        if (g >= 0) begin
            m_out_stamp = m_stamp[g];
            m_out_slot  = g;
            m_out_lost  = m_lost[g];
            m_pend[g]   = 0;
            m_lost[g]   = 0;
            m_rr        = g;
        end
        for (int i = 0; i < 8; i++) begin
            if (en && stamp_evt[i] && !m_evt[i]) begin
                if (!m_pend[i]) begin
                    m_stamp[i] = counter_val;
                    m_pend[i]  = 1;
                    m_lost[i]  = 0;
                end else begin
                    m_lost[i] = 1;
                    drops++;
                end
            end
        end
        m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
        m_evt  = stamp_evt;
    endtask

    task automatic compare();
        chk("valid", {31'b0, out_valid}, {31'b0, m_valid});
        if (m_valid) begin
            chk("stamp", out_stamp, m_out_stamp);
            chk("port", {30'b0, out_port}, 32'(m_out_slot / 2));
            chk("dir", {31'b0, out_dir}, 32'(m_out_slot % 2));
            chk("lost", {31'b0, out_lost}, {31'b0, m_out_lost});
        end
        chk("drop_cnt", {16'b0, drop_cnt}, 32'(m_drop));
    endtask

    // Advance one cycle: model the edge, then compare on the falling edge.
    task automatic step();
        @(posedge clk);
        if (reset_n) model_step();
        @(negedge clk);
        compare();
        counter_val = counter_val + 1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bit          found;
        int          n;
        logic [31:0] c2;

        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_drop", {16'b0, drop_cnt}, 32'd0);
        chk("rst_stamp", out_stamp, 32'd0);
        reset_n = 1'b1;

        // Slots 0 and 5 together: slot 0 first out of reset, then slot 5 next cycle.
        out_rdy   = 1'b1;
        stamp_evt = 8'b0010_0001;
        step();
        step();
        chk("t2_first_valid", {31'b0, out_valid}, 32'd1);
        chk("t2_first_slot", {29'b0, out_port, out_dir}, 32'd0);
        step();
        chk("t2_second_valid", {31'b0, out_valid}, 32'd1);
        chk("t2_second_slot", {29'b0, out_port, out_dir}, 32'd5);
        stamp_evt = 8'h00;
        step();
        chk("t2_idle", {31'b0, out_valid}, 32'd0);

        // Latency: rise in cycle k appears as a record in cycle k+2.
        counter_val = 32'h100;
        stamp_evt   = 8'h08;
        step();
        chk("t1_not_yet", {31'b0, out_valid}, 32'd0);
        step();
        chk("t1_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_stamp", out_stamp, 32'h100);
        chk("t1_port", {30'b0, out_port}, 32'd1);
        chk("t1_dir", {31'b0, out_dir}, 32'd1);
        chk("t1_lost", {31'b0, out_lost}, 32'd0);
        stamp_evt = 8'h00;
        repeat (3) step();

        // Hold slot 0's record, then three rises on slot 2: oldest stamp kept, two drops.
        out_rdy   = 1'b0;
        stamp_evt = 8'h01;
        step();
        step();
        c2        = counter_val;
        stamp_evt = 8'h05;
        step();
        stamp_evt = 8'h01;
        step();
        stamp_evt = 8'h05;
        step();
        stamp_evt = 8'h01;
        step();
        stamp_evt = 8'h05;
        step();
        chk("t3_drop", {16'b0, drop_cnt}, 32'd2);
        out_rdy = 1'b1;
        found   = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (!found && out_valid && out_port == 2'd1 && !out_dir) begin
                found = 1;
                chk("t3_stamp", out_stamp, c2);
                chk("t3_lost", {31'b0, out_lost}, 32'd1);
            end
        end
        chk("t3_found", {31'b0, found}, 32'd1);

        // All eight slots pending with out_rdy toggling: strict order 0..7.
        stamp_evt = 8'h00;
        out_rdy   = 1'b0;
        do_reset();
        stamp_evt = 8'hFF;
        n         = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            out_rdy = ~out_rdy;
            if (out_valid && out_rdy && n < 8) begin
                chk("t4_order", {29'b0, out_port, out_dir}, 32'(n));
                n++;
            end
        end
        chk("t4_count", 32'(n), 32'd8);
        out_rdy   = 1'b1;
        stamp_evt = 8'h00;
        repeat (4) step();

        // Rises while disabled are ignored and an already-high level never re-fires.
        en        = 1'b0;
        stamp_evt = 8'h02;
        repeat (4) step();
        chk("t5_no_rec_dis", {31'b0, out_valid}, 32'd0);
        chk("t5_drop", {16'b0, drop_cnt}, 32'd0);
        en = 1'b1;
        repeat (4) step();
        chk("t5_no_rec_en", {31'b0, out_valid}, 32'd0);
        stamp_evt = 8'h00;
        step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 5) == 0) stamp_evt[b] = ~stamp_evt[b];
            end
            en      = ($urandom_range(0, 7) != 0);
            out_rdy = ($urandom_range(0, 2) != 0);
            step();
        end

        // Saturate the drop counter with a stuck consumer, then reset mid-hold.
        en      = 1'b1;
        out_rdy = 1'b0;
        for (int i = 0; i < 17000; i++) begin
            stamp_evt = (i % 2 == 0) ? 8'hFF : 8'h00;
            step();
        end
        chk("t6_sat", {16'b0, drop_cnt}, 32'hFFFF);
        chk("t6_hold", {31'b0, out_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'b0, out_valid}, 32'd0);
        chk("t6_async_drop", {16'b0, drop_cnt}, 32'd0);
        model_reset();
        stamp_evt = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        out_rdy = 1'b1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
